// File: rtl/synth_voice_pkg.sv
// Shared types and helpers for the ADSR voice allocator.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package synth_voice_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECIDE,
        S_KICK
    } alloc_state_t;

    localparam int DEFAULT_NOTE_W = 7;

    // Width of an age value, which is also the width of a voice index.
    function automatic int AGE_W(input int num_voices);
        return (num_voices < 2) ? 1 : $clog2(num_voices);
    endfunction

endpackage

// File: rtl/voice_lru.sv
// Least-recently-allocated tracker; ages stay a permutation of 0..NUM_VOICES-1.
// Latency: touch takes effect next cycle; oldest_idx is combinational from state.
// Backpressure: none, a touch is accepted every cycle.
module voice_lru
    import synth_voice_pkg::*;
#(
    parameter int NUM_VOICES = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           touch_vld,
    input  logic [AGE_W(NUM_VOICES)-1:0]   touch_idx,
    output logic [AGE_W(NUM_VOICES)-1:0]   oldest_idx
);

    localparam int AW = AGE_W(NUM_VOICES);

    logic [AW-1:0] age_q [NUM_VOICES];
    logic [AW-1:0] age_d [NUM_VOICES];
    logic [AW-1:0] best_age;

    always_comb begin
        age_d = age_q;
        if (touch_vld) begin
            // Everything younger than the touched voice ages by one.
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (age_q[i] < age_q[touch_idx]) begin
                    age_d[i] = age_q[i] + AW'(1);
                end
            end
            age_d[touch_idx] = '0;
        end
    end

    always_comb begin
        oldest_idx = '0;
        best_age   = age_q[0];
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (age_q[i] > best_age) begin
                oldest_idx = AW'(i);
                best_age   = age_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                age_q[i] <= AW'(i);
            end
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/adsr_voice_alloc.sv
// Polyphonic note-to-voice allocator driving ADSR gates; SUSTAIN_PEDAL_EN adds a sustain pedal.
// Latency: free-voice note-on gates in 2 cycles; retrigger/steal drops gate 1 cycle, re-gates in 3.
// Backpressure: ev_ready only in S_IDLE, so one event per 2 cycles (3 for retrigger/steal).
module adsr_voice_alloc
    import synth_voice_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = DEFAULT_NOTE_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_note_on,
    input  logic [NOTE_W-1:0]            ev_note,
    input  logic [NUM_VOICES-1:0]        voice_idle,
`ifdef SUSTAIN_PEDAL_EN
    input  logic                         sustain_pedal,
`endif
    output logic [NUM_VOICES-1:0]        voice_gate,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic                         steal_pulse
);

    localparam int AW = AGE_W(NUM_VOICES);

    alloc_state_t            state_q, state_d;
    logic                    on_q, on_d;
    logic [NOTE_W-1:0]       lnote_q, lnote_d;
    logic [NUM_VOICES-1:0]   gate_q, gate_d;
    logic [NOTE_W-1:0]       note_q [NUM_VOICES];
    logic [NOTE_W-1:0]       note_d [NUM_VOICES];
    logic [AW-1:0]           victim_q, victim_d;
    logic                    steal_q, steal_d;

    logic                    touch_vld;
    logic [AW-1:0]           oldest_idx;
    logic [NUM_VOICES-1:0]   match_mask;
    logic [NUM_VOICES-1:0]   clr_mask;
    logic                    retrig_found, idle_found, free_found;
    logic [AW-1:0]           retrig_idx, idle_idx, free_idx;
    logic [AW-1:0]           pick;
    logic                    pick_steal;

`ifdef SUSTAIN_PEDAL_EN
    logic [NUM_VOICES-1:0]   held_q, held_d;
    logic                    pedal_q, pedal_d;
`endif

    voice_lru #(
        .NUM_VOICES (NUM_VOICES)
    ) u_lru (
        .clk        (clk),
        .reset      (reset),
        .touch_vld  (touch_vld),
        .touch_idx  (pick),
        .oldest_idx (oldest_idx)
    );

    // Victim priority: retrigger, silent free voice, releasing voice, oldest steal.
    always_comb begin
        retrig_found = 1'b0;
        idle_found   = 1'b0;
        free_found   = 1'b0;
        retrig_idx   = '0;
        idle_idx     = '0;
        free_idx     = '0;
        match_mask   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            match_mask[i] = gate_q[i] && (note_q[i] == lnote_q);
            if (!retrig_found && match_mask[i]) begin
                retrig_found = 1'b1;
                retrig_idx   = AW'(i);
            end
            if (!idle_found && !gate_q[i] && voice_idle[i]) begin
                idle_found = 1'b1;
                idle_idx   = AW'(i);
            end
            if (!free_found && !gate_q[i]) begin
                free_found = 1'b1;
                free_idx   = AW'(i);
            end
        end
        pick_steal = 1'b0;
        if (retrig_found) begin
            pick = retrig_idx;
        end else if (idle_found) begin
            pick = idle_idx;
        end else if (free_found) begin
            pick = free_idx;
        end else begin
            pick       = oldest_idx;
            pick_steal = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        on_d      = on_q;
        lnote_d   = lnote_q;
        gate_d    = gate_q;
        note_d    = note_q;
        victim_d  = victim_q;
        steal_d   = 1'b0;
        touch_vld = 1'b0;
        ev_ready  = 1'b0;
        clr_mask  = '0;
`ifdef SUSTAIN_PEDAL_EN
        held_d    = held_q;
        pedal_d   = sustain_pedal;
`endif
        case (state_q)
            S_IDLE: begin
                ev_ready = 1'b1;
                if (ev_valid) begin
                    on_d    = ev_note_on;
                    lnote_d = ev_note;
                    state_d = S_DECIDE;
                end
            end
            S_DECIDE: begin
                state_d = S_IDLE;
                if (on_q) begin
                    note_d[pick] = lnote_q;
                    touch_vld    = 1'b1;
                    victim_d     = pick;
`ifdef SUSTAIN_PEDAL_EN
                    held_d[pick] = 1'b0;
`endif
                    if (gate_q[pick]) begin
                        // Gate already high: pulse it low so the ADSR restarts its attack.
                        gate_d[pick] = 1'b0;
                        steal_d      = pick_steal;
                        state_d      = S_KICK;
                    end else begin
                        gate_d[pick] = 1'b1;
                    end
                end else begin
`ifdef SUSTAIN_PEDAL_EN
                    if (sustain_pedal) begin
                        held_d = held_d | match_mask;
                    end else begin
                        clr_mask = match_mask;
                    end
`else
                    clr_mask = match_mask;
`endif
                end
            end
            S_KICK: begin
                gate_d[victim_q] = 1'b1;
                state_d          = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef SUSTAIN_PEDAL_EN
        if (pedal_q && !sustain_pedal) begin
            clr_mask = clr_mask | held_q;
        end
        held_d = held_d & ~clr_mask;
`endif
        gate_d = gate_d & ~clr_mask;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            on_q     <= 1'b0;
            lnote_q  <= '0;
            gate_q   <= '0;
            victim_q <= '0;
            steal_q  <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
            end
`ifdef SUSTAIN_PEDAL_EN
            held_q   <= '0;
            pedal_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            on_q     <= on_d;
            lnote_q  <= lnote_d;
            gate_q   <= gate_d;
            victim_q <= victim_d;
            steal_q  <= steal_d;
            note_q   <= note_d;
`ifdef SUSTAIN_PEDAL_EN
            held_q   <= held_d;
            pedal_q  <= pedal_d;
`endif
        end
    end

    always_comb begin
        voice_note = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_note[i*NOTE_W +: NOTE_W] = note_q[i];
        end
    end

    assign voice_gate  = gate_q;
    assign steal_pulse = steal_q;

endmodule

// File: tb/tb_adsr_voice_alloc.sv
// Bench for adsr_voice_alloc (NUM_VOICES=4): directed table, randomized events
// against a timestamp-based allocation model, reset-in-kick and sustain sequences.
module tb_adsr_voice_alloc;

    localparam int NV = 4;
    localparam int NW = 7;

    logic              clk;
    logic              reset;
    logic              ev_valid;
    logic              ev_ready;
    logic              ev_note_on;
    logic [NW-1:0]     ev_note;
    logic [NV-1:0]     voice_idle;
    logic [NV-1:0]     voice_gate;
    logic [NV*NW-1:0]  voice_note;
    logic              steal_pulse;
`ifdef SUSTAIN_PEDAL_EN
    logic              sustain_pedal;
`endif

    adsr_voice_alloc #(.NUM_VOICES(NV), .NOTE_W(NW)) dut (
        .clk         (clk),
        .reset       (reset),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_note_on  (ev_note_on),
        .ev_note     (ev_note),
        .voice_idle  (voice_idle),
`ifdef SUSTAIN_PEDAL_EN
        .sustain_pedal (sustain_pedal),
`endif
        .voice_gate  (voice_gate),
        .voice_note  (voice_note),
        .steal_pulse (steal_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit       on;
        int       note;
        bit [3:0] idle;
        bit [3:0] exp_gate;
        int       exp_victim;
        int       exp_lat;
        int       exp_steal;
    } vec_t;

    vec_t tbl [11];

    // Reference model: a voice remembers when it was last allocated; the
    // steal victim is simply the gated voice allocated longest ago.
    bit m_gate [NV];
    int m_note [NV];
    int m_ts   [NV];
    int m_time;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < NV; i++) begin
            m_gate[i] = 1'b0;
            m_note[i] = 0;
            m_ts[i]   = -i;
        end
        m_time = 0;
    endtask

    task automatic model_event(input bit on, input int note, input bit [3:0] idle,
                               output int victim, output int lat, output int steal);
        victim = -1;
        lat    = 2;
        steal  = 0;
        if (!on) begin
            victim = 0;
            for (int i = 0; i < NV; i++)
                if (m_gate[i] && m_note[i] == note) m_gate[i] = 1'b0;
        end else begin
            for (int i = 0; i < NV; i++)
                if (victim < 0 && m_gate[i] && m_note[i] == note) victim = i;
            for (int i = 0; i < NV; i++)
                if (victim < 0 && !m_gate[i] && idle[i]) victim = i;
            for (int i = 0; i < NV; i++)
                if (victim < 0 && !m_gate[i]) victim = i;
            if (victim < 0) begin
                victim = 0;
                for (int i = 1; i < NV; i++)
                    if (m_ts[i] < m_ts[victim]) victim = i;
                steal = 1;
            end
            lat = m_gate[victim] ? 3 : 2;
            m_time++;
            m_ts[victim]   = m_time;
            m_note[victim] = note;
            m_gate[victim] = 1'b1;
        end
    endtask

    function automatic int model_gates();
        int g = 0;
        for (int i = 0; i < NV; i++) if (m_gate[i]) g |= (1 << i);
        return g;
    endfunction

    function automatic int model_notes();
        int n = 0;
        for (int i = 0; i < NV; i++) n |= (m_note[i] & 8'h7f) << (i * NW);
        return n;
    endfunction

    // Present one event in IDLE and wait for ev_ready; lat counts cycles from acceptance.
    task automatic run_event(input bit on, input int note, input bit [3:0] idle,
                             output int lat, output int steals, output bit [3:0] g2);
        chk("ready_before_event", int'(ev_ready), 1);
        voice_idle = idle;
        ev_note_on = on;
        ev_note    = NW'(note);
        ev_valid   = 1'b1;
        tick();
        ev_valid = 1'b0;
        lat      = 1;
        steals   = 0;
        g2       = voice_gate;
        while (1) begin
            steals += int'(steal_pulse);
            if (ev_ready || lat >= 10) break;
            tick();
            lat++;
            if (lat == 2) g2 = voice_gate;
        end
    endtask

    task automatic check_event(input string tag, input bit on, input int note, input bit [3:0] idle,
                               input int exp_lat, input int exp_steal, input int exp_gate,
                               input int victim);
        int       lat;
        int       steals;
        bit [3:0] g2;
        run_event(on, note, idle, lat, steals, g2);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_steal_pulses"}, steals, exp_steal);
        chk({tag, "_gates"}, int'(voice_gate), exp_gate);
        chk({tag, "_notes"}, int'(voice_note), model_notes());
        if (exp_lat == 3) chk({tag, "_kick_gate_low"}, int'(g2[victim]), 0);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int victim, lat, steal;
        bit on;
        int note;
        bit [3:0] idle;

        //         on  note idle   gate     vic lat steal
        tbl[0]  = '{1'b1, 60, 4'hF, 4'b0001, 0, 2, 0};
        tbl[1]  = '{1'b1, 62, 4'hF, 4'b0011, 1, 2, 0};
        tbl[2]  = '{1'b1, 64, 4'hF, 4'b0111, 2, 2, 0};
        tbl[3]  = '{1'b1, 65, 4'hF, 4'b1111, 3, 2, 0};
        tbl[4]  = '{1'b1, 67, 4'h0, 4'b1111, 0, 3, 1};
        tbl[5]  = '{1'b0, 62, 4'h0, 4'b1101, 0, 2, 0};
        tbl[6]  = '{1'b0, 64, 4'h0, 4'b1001, 0, 2, 0};
        tbl[7]  = '{1'b1, 70, 4'h4, 4'b1101, 2, 2, 0};
        tbl[8]  = '{1'b1, 65, 4'h0, 4'b1101, 3, 3, 0};
        tbl[9]  = '{1'b0, 50, 4'h0, 4'b1101, 0, 2, 0};
        tbl[10] = '{1'b1, 62, 4'h0, 4'b1111, 1, 2, 0};

        reset      = 1'b1;
        ev_valid   = 1'b0;
        ev_note_on = 1'b0;
        ev_note    = '0;
        voice_idle = '1;
`ifdef SUSTAIN_PEDAL_EN
        sustain_pedal = 1'b0;
`endif
        #12;
        chk("reset_gate", int'(voice_gate), 0);
        chk("reset_note", int'(voice_note), 0);
        chk("reset_steal", int'(steal_pulse), 0);
        chk("reset_ready", int'(ev_ready), 1);
        tick();
        reset = 1'b0;
        model_reset();

        for (int k = 0; k < 11; k++) begin
            model_event(tbl[k].on, tbl[k].note, tbl[k].idle, victim, lat, steal);
            check_event($sformatf("tbl%0d", k), tbl[k].on, tbl[k].note, tbl[k].idle,
                        tbl[k].exp_lat, tbl[k].exp_steal, int'(tbl[k].exp_gate),
                        tbl[k].exp_victim);
        end

        for (int k = 0; k < 150; k++) begin
            on   = ($urandom_range(0, 99) < 65);
            note = 60 + int'($urandom_range(0, 5));
            idle = 4'($urandom_range(0, 15));
            model_event(on, note, idle, victim, lat, steal);
            check_event($sformatf("rnd%0d", k), on, note, idle, lat, steal, model_gates(), victim);
        end

        // Reset landing in the gate-low cycle of a steal.
        do_reset();
        for (int v = 0; v < NV; v++) begin
            model_event(1'b1, 40 + v, 4'hF, victim, lat, steal);
            check_event($sformatf("fill%0d", v), 1'b1, 40 + v, 4'hF, lat, steal, model_gates(), victim);
        end
        voice_idle = '0;
        ev_note_on = 1'b1;
        ev_note    = NW'(44);
        ev_valid   = 1'b1;
        tick();
        ev_valid = 1'b0;
        tick();
        chk("kick_gate0_low", int'(voice_gate[0]), 0);
        reset = 1'b1;
        #1;
        chk("midkick_reset_gates", int'(voice_gate), 0);
        chk("midkick_reset_ready", int'(ev_ready), 1);
        tick();
        reset = 1'b0;
        model_reset();
        tick();
        tick();
        chk("after_reset_ready", int'(ev_ready), 1);
        chk("after_reset_gates", int'(voice_gate), 0);
        model_event(1'b1, 60, 4'hF, victim, lat, steal);
        check_event("post_reset_on", 1'b1, 60, 4'hF, lat, steal, model_gates(), victim);

`ifdef SUSTAIN_PEDAL_EN
        begin
            int       slat;
            int       ssteals;
            bit [3:0] sg2;
            sustain_pedal = 1'b1;
            tick();
            run_event(1'b0, 60, 4'h0, slat, ssteals, sg2);
            chk("sus_off_latency", slat, 2);
            chk("sus_held_gate", int'(voice_gate), 1);
            sustain_pedal = 1'b0;
            #1;
            chk("sus_edge_gate_still", int'(voice_gate), 1);
            tick();
            chk("sus_release_gate", int'(voice_gate), 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
